// File: rtl/m_cp0_pkg.sv
// Shared definitions for the CP0 exception/interrupt receiver:
// register numbers, ExcCode values, field bit positions, handler entry.
package m_cp0_pkg;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  // CP0 register numbers
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  // Field bit positions
  localparam int unsigned SR_IE_BIT      = 0;
  localparam int unsigned SR_EXL_BIT     = 1;
  localparam int unsigned IM_LO          = 10;
  localparam int unsigned IM_HI          = 15;
  localparam int unsigned CAUSE_BD_BIT   = 31;
  localparam int unsigned CAUSE_EXC_LO   = 2;
  localparam int unsigned CAUSE_EXC_HI   = 6;

endpackage

// File: rtl/m_cp0_timer.sv
// Count/Compare timer for CP0 (only present when CP0_TIMER_EN is defined).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_we_count        mtc0 to Count this cycle
//   i_we_compare      mtc0 to Compare this cycle
//   i_din             mtc0 write data
//   o_count           current Count
//   o_compare         current Compare
//   o_ti              timer interrupt pending
`ifdef CP0_TIMER_EN
module m_cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_we_count,
  input  logic        i_we_compare,
  input  logic [31:0] i_din,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_compare <= '0;
      r_ti      <= 1'b0;
    end else begin
      r_count <= i_we_count ? i_din : r_count + 32'd1;
      if (i_we_compare) begin
        r_compare <= i_din;
      end
      // A Compare write clears TI even if the match occurs in the same cycle
      if (i_we_compare) begin
        r_ti <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ti      = r_ti;

endmodule
`endif

// File: rtl/m_cp0.sv
// CP0 exception/interrupt receiver at the M stage. Holds SR, Cause, EPC,
// arbitrates interrupts over synchronous exceptions and raises Req to flush
// the pipeline. Services mfc0 (A1/DOut), mtc0 (A2/DIn/WE) and eret (EXLClr).
// Optional macro CP0_TIMER_EN adds Count(9)/Compare(11) and timer interrupt
// on IP[15].
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   A1             mfc0 read register number
//   A2, DIn, WE    mtc0 register number, data, enable
//   VPC, BDIn      PC of M instruction, delay-slot flag
//   ExcCodeIn      pipelined exception code (0 = none)
//   HWInt          level-sensitive external interrupt lines
//   EXLClr         eret in M
//   DOut           mfc0 read data (combinational)
//   EPCOut         current EPC
//   Req            take exception/interrupt this cycle (combinational)
module m_cp0
  import m_cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = m_cp0_pkg::HANDLER_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_ti;
  logic [5:0]  w_ip_eff;
  logic        w_int_req;
  logic        w_exc_req;
  logic [31:0] w_epc_raw;
  logic [31:0] w_epc_next;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        w_mtc0;

`ifdef CP0_TIMER_EN
  logic [31:0] w_count;
  logic [31:0] w_compare;

  m_cp0_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_we_count   (w_mtc0 && (A2 == CP0_COUNT)),
    .i_we_compare (w_mtc0 && (A2 == CP0_COMPARE)),
    .i_din        (DIn),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ti         (w_ti)
  );
`else
  assign w_ti = 1'b0;
`endif

  assign w_ip_eff  = {HWInt[5] | w_ti, HWInt[4:0]};
  assign w_int_req = r_ie & ~r_exl & (|(w_ip_eff & r_im));
  assign w_exc_req = ~r_exl & (ExcCodeIn != 5'd0);
  // Gated by reset so a reset mid-exception drops Req in the same cycle
  assign Req       = ~reset & (w_int_req | w_exc_req);
  assign w_mtc0    = WE & ~Req;

  assign w_epc_raw  = BDIn ? (VPC - 32'd4) : VPC;
  assign w_epc_next = {w_epc_raw[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= w_ip_eff;
      if (Req) begin
        r_exl     <= 1'b1;
        r_exccode <= w_int_req ? EXC_INT : ExcCodeIn;
        r_bd      <= BDIn;
        r_epc     <= w_epc_next;
      end else begin
        if (w_mtc0 && (A2 == CP0_SR)) begin
          r_im  <= DIn[IM_HI:IM_LO];
          r_exl <= DIn[SR_EXL_BIT];
          r_ie  <= DIn[SR_IE_BIT];
        end
        if (w_mtc0 && (A2 == CP0_EPC)) begin
          r_epc <= DIn;
        end
        // eret overrides only the EXL bit of a coincident SR write
        if (EXLClr) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_sr                          = '0;
    w_sr[IM_HI:IM_LO]             = r_im;
    w_sr[SR_EXL_BIT]              = r_exl;
    w_sr[SR_IE_BIT]               = r_ie;
    w_cause                       = '0;
    w_cause[CAUSE_BD_BIT]         = r_bd;
    w_cause[IM_HI:IM_LO]          = r_ip;
    w_cause[CAUSE_EXC_HI:CAUSE_EXC_LO] = r_exccode;
  end

  always_comb begin
    DOut = '0;
    case (A1)
      CP0_SR:      DOut = w_sr;
      CP0_CAUSE:   DOut = w_cause;
      CP0_EPC:     DOut = r_epc;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   DOut = w_count;
      CP0_COMPARE: DOut = w_compare;
`endif
      default:     DOut = '0;
    endcase
  end

  assign EPCOut = r_epc;

endmodule
